ntt_conf_sequencer: RTL and testbench
=====================================

NTT_CONF_SEQUENCER -- requirements
Module: ntt_conf_sequencer

Interface
REQ-001 SHALL have parameter IDLE_CONF, default 4'd0; conf value driven whenever no step is active.
REQ-002 SHALL have parameter TIMEOUT, default 16'd8192; maximum cycles a flag-wait step may hold before error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we  input  1  step-table write strobe.
REQ-006 SHALL have port cfg_addr  input  3  step-table index 0..7.
REQ-007 SHALL have port cfg_data  input  18  step entry: [17:14] conf code, [13:12] wait mode, [11:0] cycle count.
REQ-008 SHALL have port num_steps  input  4  steps to run, 1..8; sampled at start.
REQ-009 SHALL have port start  input  1  one-cycle run request.
REQ-010 SHALL have port abort  input  1  cancel run.
REQ-011 SHALL have port done_flag  input  2  completion flags returned by the NTT core (top_stage).
REQ-012 SHALL have port conf  output  4  configuration code driven to the NTT core.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port seq_done  output  1  one-cycle pulse after last step.
REQ-015 SHALL have port err  output  1  sticky timeout indicator.
REQ-016 SHALL have port err_step  output  3  index of step that timed out.

Function
REQ-017 SHALL hold an 8-entry x 18-bit step table; write on cfg_we only when not busy; writes while busy dropped.
REQ-018 SHALL implement states IDLE, RUN, FINISH, ERROR.
REQ-019 IDLE: start with num_steps in 1..8 -> RUN, step index 0, latch num_steps; start with num_steps 0 or >8 ignored.
REQ-020 SHALL drive conf = table[idx].conf in the cycle after start is sampled (1-cycle latency) and every RUN cycle for that step.
REQ-021 Wait mode 00: step lasts exactly count cycles; count 0 treated as 1.
REQ-022 Wait mode 01/10/11: step holds until done_flag[0] / done_flag[1] / both sampled high; advance takes effect next cycle.
REQ-023 Step advance SHALL be back-to-back: next step's conf appears the cycle after the current step ends, no IDLE_CONF gap.
REQ-024 Flag-wait step exceeding TIMEOUT cycles SHALL -> ERROR: err=1, err_step=idx, conf=IDLE_CONF.
REQ-025 Completion of step num_steps-1 SHALL -> FINISH for one cycle: seq_done=1, conf=IDLE_CONF, busy=0; then IDLE.
REQ-026 ERROR SHALL persist until start (clears err, starts new run per REQ-019) or rst.
REQ-027 abort in RUN SHALL -> IDLE next cycle, conf=IDLE_CONF, no seq_done, err unchanged; abort wins over simultaneous step end.
REQ-028 start while busy SHALL be ignored; start and abort same cycle in IDLE: abort wins, stays IDLE.
REQ-029 Cycle and timeout counters SHALL reset on every step entry; no wrap-around (saturate).
REQ-030 done_flag high outside a flag-wait step SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE, conf=IDLE_CONF, busy=0, seq_done=0, err=0, err_step=0, counters 0, at next edge including mid-run.
REQ-032 Step table contents SHALL NOT be cleared by rst.

Verification
V1: table {0:(1,00,128),1:(3,00,16),2:(2,01,0)}, num_steps=3, start; done_flag[0] high at cycle 700 -> conf=1 for 128 cycles, 3 for 16, 2 until cycle 701, seq_done one pulse, conf=0.
V2: step 0 = (4,10,0), TIMEOUT=64, done_flag held 0 -> after 64 cycles err=1, err_step=0, conf=0; next start clears err.
V3: abort in step 1 same cycle as its count expires -> IDLE, conf=0, no seq_done, busy=0.
V4: cfg_we to addr 0 while busy -> entry unchanged on rerun; start while busy -> no restart.
V5: rst asserted mid-run -> next cycle conf=0, busy=0, err=0; table retained, rerun reproduces V1.
V6: num_steps=0 with start -> stays IDLE; step count=0 mode 00 -> conf held exactly 1 cycle.

Source files
------------

// File: rtl/ntt_conf_sequencer.sv
// Step-table driven configuration sequencer for the NTT core: walks up to eight
// programmed steps, each timed by a cycle count or by completion flags.
module ntt_conf_sequencer #(
    parameter logic [3:0]  IDLE_CONF = 4'd0,
    parameter logic [15:0] TIMEOUT   = 16'd8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [17:0] cfg_data,
    input  logic [3:0]  num_steps,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  done_flag,
    output logic [3:0]  conf,
    output logic        busy,
    output logic        seq_done,
    output logic        err,
    output logic [2:0]  err_step
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        WAIT_COUNT = 2'b00,
        WAIT_FLAG0 = 2'b01,
        WAIT_FLAG1 = 2'b10,
        WAIT_BOTH  = 2'b11
    } wait_t;

    typedef struct packed {
        logic [3:0]  code;
        wait_t       mode;
        logic [11:0] count;
    } step_t;

    state_t      state;
    step_t       step_table [8];
    logic [2:0]  idx;
    logic [3:0]  steps_q;
    logic [15:0] cnt;

    step_t       cur_step;
    logic [3:0]  next_code;
    logic [15:0] step_len;
    logic        flag_hit;
    logic        step_end;
    logic        timeout_hit;
    logic        last_step;
    logic        run_ok;

    // NOTE: the step table has no reset so it keeps its program across rst and
    // maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (cfg_we && state != ST_RUN)
            step_table[cfg_addr] <= step_t'(cfg_data);
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cur_step  = step_table[idx];
        next_code = step_table[idx + 3'd1].code;
        step_len  = (cur_step.count == 12'd0) ? 16'd1 : {4'd0, cur_step.count};
        flag_hit  = 1'b0;
        case (cur_step.mode)
            WAIT_FLAG0: flag_hit = done_flag[0];
            WAIT_FLAG1: flag_hit = done_flag[1];
            WAIT_BOTH:  flag_hit = &done_flag;
            default:    flag_hit = 1'b0;
        endcase
        step_end    = (cur_step.mode == WAIT_COUNT) ? (cnt >= step_len) : flag_hit;
        timeout_hit = (cur_step.mode != WAIT_COUNT) && !flag_hit && (cnt >= TIMEOUT);
        last_step   = ({1'b0, idx} + 4'd1) == steps_q;
        run_ok      = start && !abort && (num_steps != 4'd0) && (num_steps <= 4'd8);
    end

    // cnt counts the cycles the current step has been presented, starting at 1.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            steps_q  <= 4'd0;
            cnt      <= 16'd0;
            conf     <= IDLE_CONF;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_step <= 3'd0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (run_ok) begin
                        state   <= ST_RUN;
                        idx     <= 3'd0;
                        steps_q <= num_steps;
                        cnt     <= 16'd1;
                        conf    <= step_table[0].code;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        cnt   <= 16'd0;
                        conf  <= IDLE_CONF;
                        busy  <= 1'b0;
                    end else if (timeout_hit) begin
                        state    <= ST_ERROR;
                        cnt      <= 16'd0;
                        conf     <= IDLE_CONF;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_step <= idx;
                    end else if (step_end && last_step) begin
                        state    <= ST_FINISH;
                        cnt      <= 16'd0;
                        conf     <= IDLE_CONF;
                        busy     <= 1'b0;
                        seq_done <= 1'b1;
                    end else if (step_end) begin
                        idx  <= idx + 3'd1;
                        cnt  <= 16'd1;
                        conf <= next_code;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Randomized bench for ntt_conf_sequencer: a per-run expected trace is built from
// the step table and the planned flag/abort timing, then compared cycle by cycle.
module tb_ntt_conf_sequencer;

    localparam logic [3:0] IDLE_CONF = 4'd0;
    localparam int         TO        = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic [3:0]  num_steps;
    logic        start;
    logic        abort;
    logic [1:0]  done_flag;
    logic [3:0]  conf;
    logic        busy;
    logic        seq_done;
    logic        err;
    logic [2:0]  err_step;

    ntt_conf_sequencer #(.IDLE_CONF(IDLE_CONF), .TIMEOUT(16'(TO))) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .num_steps(num_steps), .start(start), .abort(abort), .done_flag(done_flag),
        .conf(conf), .busy(busy), .seq_done(seq_done), .err(err), .err_step(err_step)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int mode; int count; } ent_t;

    ent_t        mtab [8];
    int          waits [8];
    int          m_err;
    int          m_err_step;
    int          ab_at = -1;
    int          st_at = -1;
    int          we_at = -1;
    logic [17:0] we_word;
    int          n_checks;
    int          n_fail;

    int         e_conf [$];
    int         e_busy [$];
    int         e_done [$];
    int         e_err [$];
    int         e_estep [$];
    logic [1:0] f_drv [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] nonsat(input int mode);
        case (mode)
            1: return {1'($urandom), 1'b0};
            2: return {1'b0, 1'($urandom)};
            3: return 2'($urandom_range(0, 2));
            default: return 2'($urandom);
        endcase
    endfunction

    function automatic logic [1:0] sat(input int mode);
        case (mode)
            1: return {1'($urandom), 1'b1};
            2: return {1'b1, 1'($urandom)};
            default: return 2'b11;
        endcase
    endfunction

    task automatic push(input int c, input int b, input int d, input int e, input int s, input logic [1:0] f);
        e_conf.push_back(c);
        e_busy.push_back(b);
        e_done.push_back(d);
        e_err.push_back(e);
        e_estep.push_back(s);
        f_drv.push_back(f);
    endtask

    task automatic write_entry(input int a, input int code, input int mode, input int count);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = {4'(code), 2'(mode), 12'(count)};
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        mtab[a]  = '{code, mode, count};
    endtask

    task automatic check_outputs(input int c, input int b, input int d, input int e, input int s);
        check("conf", {28'd0, conf}, c);
        check("busy", {31'd0, busy}, b);
        check("seq_done", {31'd0, seq_done}, d);
        check("err", {31'd0, err}, e);
        check("err_step", {29'd0, err_step}, s);
    endtask

    // Expected trace: each step contributes the cycles it must be presented,
    // then FINISH/ERROR/abort tails follow.
    task automatic run_seq(input int n);
        int old_estep;
        int run_len;
        int err_k;
        int limit;
        bit errd;
        old_estep = m_err_step;
        run_len   = 0;
        err_k     = 0;
        errd      = 1'b0;
        e_conf.delete(); e_busy.delete(); e_done.delete();
        e_err.delete(); e_estep.delete(); f_drv.delete();
        for (int k = 0; k < n && !errd; k++) begin
            ent_t e;
            e = mtab[k];
            if (e.mode == 0) begin
                int len;
                len = (e.count == 0) ? 1 : e.count;
                for (int j = 0; j < len; j++) push(e.code, 1, 0, 0, old_estep, 2'($urandom));
                run_len += len;
            end else if (waits[k] < TO) begin
                for (int j = 0; j <= waits[k]; j++)
                    push(e.code, 1, 0, 0, old_estep, (j == waits[k]) ? sat(e.mode) : nonsat(e.mode));
                run_len += waits[k] + 1;
            end else begin
                for (int j = 0; j < TO; j++) push(e.code, 1, 0, 0, old_estep, nonsat(e.mode));
                run_len += TO;
                errd  = 1'b1;
                err_k = k;
            end
        end
        if (errd) begin
            repeat (3) push(IDLE_CONF, 0, 0, 1, err_k, 2'($urandom));
        end else begin
            push(IDLE_CONF, 0, 1, 0, old_estep, 2'($urandom));
            repeat (2) push(IDLE_CONF, 0, 0, 0, old_estep, 2'($urandom));
        end
        if (ab_at >= 0 && ab_at < run_len) begin
            while (e_conf.size() > ab_at + 1) begin
                void'(e_conf.pop_back()); void'(e_busy.pop_back()); void'(e_done.pop_back());
                void'(e_err.pop_back()); void'(e_estep.pop_back()); void'(f_drv.pop_back());
            end
            errd = 1'b0;
            repeat (3) push(IDLE_CONF, 0, 0, 0, old_estep, 2'($urandom));
            limit = ab_at + 1;
        end else begin
            ab_at = -1;
            limit = run_len;
        end
        if (st_at >= limit) st_at = -1;
        if (we_at >= limit) we_at = -1;
        m_err = errd ? 1 : 0;
        if (errd) m_err_step = err_k;

        @(posedge clk); #1;
        num_steps = 4'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < e_conf.size(); i++) begin
            done_flag = f_drv[i];
            abort     = (i == ab_at);
            start     = (i == st_at);
            cfg_we    = (i == we_at);
            cfg_addr  = 3'd0;
            cfg_data  = we_word;
            @(negedge clk);
            check_outputs(e_conf[i], e_busy[i], e_done[i], e_err[i], e_estep[i]);
            @(posedge clk); #1;
        end
        done_flag = 2'b00;
        abort     = 1'b0;
        start     = 1'b0;
        cfg_we    = 1'b0;
        ab_at     = -1;
        st_at     = -1;
        we_at     = -1;
    endtask

    task automatic bad_start(input int n, input bit ab);
        @(posedge clk); #1;
        num_steps = 4'(n);
        start     = 1'b1;
        abort     = ab;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_busy", {31'd0, busy}, 0);
            check("ignored_start_conf", {28'd0, conf}, IDLE_CONF);
            check("ignored_start_done", {31'd0, seq_done}, 0);
            check("ignored_start_err", {31'd0, err}, m_err);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        m_err      = 0;
        m_err_step = 0;
        @(negedge clk);
        check_outputs(IDLE_CONF, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_steps = '0;
        start = 1'b0; abort = 1'b0; done_flag = 2'b00; we_word = '0;
        m_err = 0; m_err_step = 0; n_checks = 0; n_fail = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs(IDLE_CONF, 0, 0, 0, 0);

        for (int a = 0; a < 8; a++) write_entry(a, $urandom % 16, 0, $urandom_range(1, 5));

        // Invalid step counts and start+abort in IDLE are ignored
        bad_start(0, 1'b0);
        bad_start(9, 1'b0);
        bad_start(15, 1'b0);
        bad_start(3, 1'b1);

        // Basic three-step program: two counted steps then a flag0 wait
        write_entry(0, 1, 0, 128);
        write_entry(1, 3, 0, 16);
        write_entry(2, 2, 1, 0);
        waits[2] = 50;
        run_seq(3);

        // Table write and start while busy are dropped; rerun is unchanged
        we_word = {4'd9, 2'd0, 12'd5};
        we_at   = 10;
        st_at   = 20;
        run_seq(3);
        run_seq(3);

        // Abort on the last cycle of step 1, both mid-program and as the final step
        ab_at = 143;
        run_seq(3);
        ab_at = 143;
        run_seq(2);

        // Flag1 wait: satisfied on the last allowed cycle, then one cycle too late
        write_entry(0, 4, 2, 0);
        waits[0] = TO - 1;
        run_seq(1);
        waits[0] = TO;
        run_seq(1);
        bad_start(0, 1'b0);
        do_reset();
        waits[0] = TO + 20;
        run_seq(1);
        write_entry(0, 1, 0, 128);
        run_seq(3);

        // Reset mid-run, then the retained table reproduces the same run
        @(posedge clk); #1;
        num_steps = 4'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("midrun_busy", {31'd0, busy}, 1);
            check("midrun_conf", {28'd0, conf}, 1);
            @(posedge clk); #1;
        end
        do_reset();
        run_seq(3);

        // Zero-count steps last exactly one cycle each
        write_entry(0, 5, 0, 0);
        write_entry(1, 6, 0, 0);
        write_entry(2, 7, 3, 0);
        waits[2] = 0;
        run_seq(3);

        for (int r = 0; r < 40; r++) begin
            int n;
            if ($urandom % 2 == 0)
                for (int a = 0; a < 8; a++) write_entry(a, $urandom % 16, $urandom % 4, $urandom % 20);
            n = $urandom_range(1, 8);
            for (int k = 0; k < 8; k++) waits[k] = $urandom_range(0, TO + 6);
            if ($urandom % 4 == 0) ab_at = $urandom % 150;
            if ($urandom % 4 == 0) st_at = $urandom % 60;
            if ($urandom % 4 == 0) begin
                we_at   = $urandom % 60;
                we_word = 18'($urandom);
            end
            run_seq(n);
            if ($urandom % 5 == 0) bad_start(($urandom % 2 == 0) ? 0 : $urandom_range(9, 15), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
